// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with toggle / up-count / down-count / hold modes.
// Define TFF_BANK_PARITY_EN to add a combinational parity output over q.
module t_ff_bank #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`ifdef TFF_BANK_PARITY_EN
    output logic             parity,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] tmask;
    logic             carry;
    logic             borrow;

    assign mode_s = mode_e'(mode);

    // Counting is built from per-bit toggle enables: a bit toggles when every
    // lower bit is 1 (up) or 0 (down).
    always_comb begin
        tmask  = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case (mode_s)
                MODE_TOGGLE: tmask[i] = t[i];
                MODE_UP:     tmask[i] = carry;
                MODE_DOWN:   tmask[i] = borrow;
                MODE_HOLD:   tmask[i] = 1'b0;
                default:     tmask[i] = 1'b0;
            endcase
            carry  = carry  & q[i];
            borrow = borrow & ~q[i];
        end
    end

    assign tc = ((mode_s == MODE_UP) && (&q)) || ((mode_s == MODE_DOWN) && (~|q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= d;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q ^ tmask;
            wrap <= tc;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign qb = ~q;

`ifdef TFF_BANK_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_t_ff_bank.sv
// Scoreboard bench for t_ff_bank (WIDTH=4, RST_VAL=0): directed scenarios then random stimulus.
module tb_t_ff_bank;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b11;
    logic [W-1:0] t = '0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         tc;
    logic         wrap;
`ifdef TFF_BANK_PARITY_EN
    logic         parity;
`endif

    t_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .d(d),
`ifdef TFF_BANK_PARITY_EN
        .parity(parity),
`endif
        .q(q), .qb(qb), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned q;
        bit          wrap;
    } exp_t;

    exp_t        sb[$];
    int unsigned mq = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(input int unsigned m, input int unsigned qv);
        return (m == 1 && qv == MASK) || (m == 2 && qv == 0);
    endfunction

    // Apply one cycle of inputs, check tc against the model, queue the post-edge expectation.
    task automatic drive(input bit r, input bit e, input int unsigned m,
                         input int unsigned tv, input bit l, input int unsigned dv);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = 2'(m); t = W'(tv); load = l; d = W'(dv);
        if (r) mq = 0;
        #1;
        check("tc", tc, model_tc(m, mq));
        x.wrap = 1'b0;
        if (r)           x.q = 0;
        else if (l)      x.q = dv & MASK;
        else if (e) begin
            case (m)
                0: x.q = mq ^ tv;
                1: begin x.q = (mq + 1) & MASK; x.wrap = (mq == MASK); end
                2: begin x.q = (mq + MASK) & MASK; x.wrap = (mq == 0); end
                default: x.q = mq;
            endcase
        end else         x.q = mq;
        sb.push_back(x);
        mq = x.q;
    endtask

    task automatic pulse_reset();
        exp_t x;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_q", q, 0);
        check("async_rst_qb", qb, MASK);
        check("async_rst_wrap", wrap, 0);
        mq = 0;
        #1 rst = 1'b0;
        load = 1'b0; en = 1'b0;
        x.q = mq; x.wrap = 1'b0;
        sb.push_back(x);
    endtask

    // Monitor: one registered result per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("q", q, x.q);
                check("qb", qb, ~x.q & MASK);
                check("wrap", wrap, x.wrap);
`ifdef TFF_BANK_PARITY_EN
                check("parity", parity, ^(W'(x.q)));
`endif
            end
        end
    end

    initial begin
        int unsigned guard;
        #1;
        check("reset_q", q, 0);
        check("reset_qb", qb, MASK);
        check("reset_wrap", wrap, 0);

        drive(1, 0, 3, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0, 0);
        // toggle patterns
        drive(0, 1, 0, 4'b0101, 0, 0);
        drive(0, 1, 0, 4'b0000, 0, 0);
        drive(0, 1, 0, 4'b1111, 0, 0);
        // up-count wrap
        drive(0, 1, 1, 0, 1, 4'b1101);
        repeat (4) drive(0, 1, 1, 0, 0, 0);
        // down-count wrap
        drive(0, 0, 2, 0, 1, 4'b0001);
        repeat (3) drive(0, 1, 2, 0, 0, 0);
        // load beats terminal count
        drive(0, 0, 1, 0, 1, 4'b1111);
        drive(0, 1, 1, 0, 1, 4'b0011);
        repeat (2) drive(0, 1, 3, 0, 0, 0);
        // mid-cycle reset
        drive(0, 0, 0, 0, 1, 4'b1010);
        pulse_reset();
        drive(0, 1, 1, 0, 0, 0);

        repeat (600) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, MASK),
                  $urandom_range(0, 7) == 0, $urandom_range(0, MASK));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/t_ff_bank.md
T_FF_BANK -- requirements
Module: t_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of toggle flip-flops; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port en, input, 1: cycle enable; when 0, q holds unless load=1.
REQ-006 Port mode, input, 2: 00 toggle, 01 count up, 10 count down, 11 hold.
REQ-007 Port t, input, WIDTH: per-bit toggle request; used only in toggle mode.
REQ-008 Port load, input, 1: synchronous parallel load of d.
REQ-009 Port d, input, WIDTH: load data.
REQ-010 Port q, output, WIDTH: registered flip-flop state.
REQ-011 Port qb, output, WIDTH: bitwise complement of q at all times, including during reset.
REQ-012 Port tc, output, 1: combinational terminal-count flag.
REQ-013 Port wrap, output, 1: registered one-cycle pulse after a count wrap.

Function
REQ-014 Priority per edge SHALL be: rst > load > (en and mode) > hold.
REQ-015 load=1 SHALL set q<=d on the next edge, regardless of en and mode; wrap<=0.
REQ-016 Toggle mode (en=1, mode=00): each bit SHALL be q[i]<=q[i]^t[i]; t=0 holds, all-ones t inverts all bits.
REQ-017 Up mode (en=1, mode=01): bit i SHALL toggle when all lower bits are 1 (bit 0 always toggles), giving q+1 mod 2^WIDTH.
REQ-018 Down mode (en=1, mode=10): bit i SHALL toggle when all lower bits are 0 (bit 0 always toggles), giving q-1 mod 2^WIDTH.
REQ-019 Hold mode (mode=11) or en=0 SHALL leave q unchanged.
REQ-020 tc SHALL be 1 when (mode=01 and q all ones) or (mode=10 and q all zeros), regardless of en; otherwise 0.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge where en=1, load=0, and tc=1 (up: all-ones to 0; down: 0 to all-ones); otherwise 0.
REQ-022 Toggle mode SHALL never assert wrap, even when q passes through all ones or all zeros.
REQ-023 A mode change SHALL take effect on the same edge; no pipeline latency; q reflects the new mode's update one edge later.
REQ-024 Simultaneous load=1 and tc=1 with en=1: load wins, wrap stays 0.

Reset
REQ-025 While rst=1, q SHALL be RST_VAL, qb SHALL be ~RST_VAL, and wrap SHALL be 0, asynchronously, without waiting for clk.
REQ-026 Reset asserted mid-count SHALL abandon the count; the first edge after deassertion operates normally from RST_VAL.
REQ-027 tc during reset SHALL follow REQ-020 using q=RST_VAL.

Configuration
REQ-028 Macro TFF_BANK_PARITY_EN defined: add output port parity, 1 bit, equal to XOR of all q bits (combinational), 0 parity for RST_VAL=0.
REQ-029 Macro TFF_BANK_PARITY_EN undefined: parity port and logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=4, RST_VAL=0)
REQ-030 rst=1 then released; hold with en=0 for 3 edges -> q=0000, qb=1111, wrap=0.
REQ-031 Toggle mode, q=0000: t=0101, then t=0000, then t=1111 -> q=0101, 0101, 1010; wrap stays 0.
REQ-032 Up mode from load d=1101, en=1 for 4 edges -> q=1110, 1111 (tc=1), 0000 (wrap=1 this cycle), 0001 (wrap=0).
REQ-033 Down mode from q=0001 for 3 edges -> q=0000 (tc=1), 1111 (wrap=1), 1110.
REQ-034 Up mode, q=1111, en=1 with load=1 and d=0011 -> q=0011, wrap=0; then mode=11 for 2 edges -> q=0011.
REQ-035 rst pulsed between clock edges with q=1010 -> q=0000 immediately, before the next rising edge; wrap=0.
